param_rf: RTL and testbench
===========================

Name: param_rf

Overview:
- Parametrised software/hardware register file, generalising the single-register RF to NUM_REGS registers of DATA_WIDTH bits.
- Sits between the host-side register access bus and the hardware it configures/monitors.
- Per-register software-writability and counter mode, selected by parameter masks.
- Adds out-of-range address detection and a one-cycle access_complete handshake.

Parameters:
NUM_REGS, 4, number of registers; 1..2**ADDR_WIDTH
DATA_WIDTH, 64, register width in bits
ADDR_WIDTH, 2, word-address width
SW_WR_MASK, 4'b0111, bit i=1: register i software-writable; 0: software read-only
CNT_MASK, 4'b1000, bit i=1: register i increments on hw_inc[i]

Ports:
clk  in  1  clock
res  in  1  synchronous active-high reset
address  in  ADDR_WIDTH  word address of software access
read_en  in  1  software read request, single-cycle pulse
write_en  in  1  software write request, single-cycle pulse
write_data  in  DATA_WIDTH  software write data
read_data  out  DATA_WIDTH  registered read data
access_complete  out  1  one-cycle pulse, access finished
invalid_address  out  1  one-cycle pulse with access_complete, address >= NUM_REGS
hw_next  in  NUM_REGS*DATA_WIDTH  hardware write data, register i at [i*DATA_WIDTH +: DATA_WIDTH]
hw_wen  in  NUM_REGS  per-register hardware write enable
hw_inc  in  NUM_REGS  per-register increment strobe (ignored where CNT_MASK[i]=0)
reg_q  out  NUM_REGS*DATA_WIDTH  current register contents, same packing

Behaviour:
- Reset, sampled on rising clk while res=1: all registers 0, read_data 0, access_complete 0, invalid_address 0. Reset overrides any access in the same cycle; no completion is generated for it.
- Access latency:
  - Request sampled at edge N; access_complete=1 for exactly the cycle after edge N.
  - read_data is valid in that same cycle and holds its value until the next read completes.
  - One request per cycle; back-to-back requests on consecutive cycles are legal.
- read_en and write_en both high: treated as a write; the read is dropped and read_data is unchanged.
- Invalid address (address >= NUM_REGS):
  - access_complete=1 and invalid_address=1; no register changes.
  - A read returns read_data=0.
- Software write to a register with SW_WR_MASK[i]=0: completes normally with invalid_address=0; the write is ignored.
- Per-register update priority at each edge:
  1. hw_wen[i]: reg <= hw_next slice.
  2. Software write to i (if writable): reg <= write_data.
  3. CNT_MASK[i] && hw_inc[i]: reg <= reg+1, modulo 2**DATA_WIDTH, so all-ones wraps to 0 with no overflow flag.
  4. Otherwise hold.
- A losing software write still pulses access_complete.
- A losing increment is lost, not deferred.
- Read/update collision: a software read sampled at the same edge as a register update returns the pre-update value.
- reg_q is a direct view of the register flops, with no extra latency.
- access_complete is combinationally independent of inputs (registered).

Test Plan:
- res=1 for 4 cycles, then release → reg_q all 0, read_data 0, access_complete 0.
- Write 64'h555AAA555AAA555A to address 0 → next cycle access_complete=1, invalid_address=0, reg_q[63:0]=64'h555AAA555AAA555A. Read address 0 → read_data=64'h555AAA555AAA555A.
- Same cycle: write 64'h1 to addr 1 and hw_wen[1]=1 with hw_next slice 64'hDEAD → reg 1 = 64'hDEAD, access_complete=1.
- Write 64'hFFFF to addr 3 (read-only counter) → reg 3 stays 0. Pulse hw_inc[3] three times → read returns 3. hw_wen[3] loads 64'hFFFFFFFFFFFFFFFF, then one hw_inc → reg 3 = 0 (wrap).
- Read address 4 with ADDR_WIDTH=3, NUM_REGS=4 → access_complete=1, invalid_address=1, read_data=0, all registers unchanged.
- Assert read_en and write_en together at addr 2 with data 64'h77, and assert res mid-sequence → the write lands (reg 2=64'h77) and read_data is unchanged. The res cycle clears everything with no access_complete.

Source files
------------

// File: rtl/param_rf.sv
// param_rf: NUM_REGS x DATA_WIDTH software/hardware register file.
// Software accesses complete one cycle after they are sampled. Hardware can
// load any register, and registers selected by CNT_MASK count on hw_inc.
module param_rf #(
  parameter int unsigned         NUM_REGS   = 4,
  parameter int unsigned         DATA_WIDTH = 64,
  parameter int unsigned         ADDR_WIDTH = 2,
  parameter logic [NUM_REGS-1:0] SW_WR_MASK = NUM_REGS'(4'b0111),
  parameter logic [NUM_REGS-1:0] CNT_MASK   = NUM_REGS'(4'b1000)
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           read_en,
  input  logic                           write_en,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           access_complete,
  output logic                           invalid_address,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_next,
  input  logic [NUM_REGS-1:0]            hw_wen,
  input  logic [NUM_REGS-1:0]            hw_inc,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  access_complete_q, access_complete_d;
  logic                  invalid_address_q, invalid_address_d;

  logic                  addr_valid_c;
  logic                  sw_read_c;
  logic                  access_c;
  logic [DATA_WIDTH-1:0] rd_mux_c;

  // Address decode; a simultaneous read and write is treated as a write only.
  assign addr_valid_c = ({1'b0, address} < AW1'(NUM_REGS));
  assign access_c     = read_en | write_en;
  assign sw_read_c    = read_en & ~write_en;

  // Read mux over the pre-update register values; unmapped addresses read 0.
  always_comb begin
    rd_mux_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (addr_valid_c && (address == ADDR_WIDTH'(i))) begin
        rd_mux_c = regs_q[i];
      end
    end
  end

  // Next-state: per-register priority hw load > sw write > increment > hold.
  always_comb begin
    regs_d            = regs_q;
    read_data_d       = read_data_q;
    access_complete_d = access_c;
    invalid_address_d = access_c & ~addr_valid_c;

    if (sw_read_c) begin
      read_data_d = rd_mux_c;
    end

    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (hw_wen[i]) begin
        regs_d[i] = hw_next[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (write_en && addr_valid_c && (address == ADDR_WIDTH'(i)) && SW_WR_MASK[i]) begin
        regs_d[i] = write_data;
      end else if (CNT_MASK[i] && hw_inc[i]) begin
        regs_d[i] = regs_q[i] + DATA_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset; reset suppresses any completion.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      read_data_q       <= '0;
      access_complete_q <= 1'b0;
      invalid_address_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      read_data_q       <= read_data_d;
      access_complete_q <= access_complete_d;
      invalid_address_q <= invalid_address_d;
    end
  end

  // Flat view of the register flops.
  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regq
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign read_data       = read_data_q;
  assign access_complete = access_complete_q;
  assign invalid_address = invalid_address_q;

endmodule

// File: tb/tb_param_rf.sv
// Bench for param_rf: directed scenarios followed by random traffic, checked
// against a behavioural model of the register file.
module tb_param_rf;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 3;

  logic               clk;
  logic               res;
  logic [AW-1:0]      address;
  logic               read_en;
  logic               write_en;
  logic [DW-1:0]      write_data;
  logic [DW-1:0]      read_data;
  logic               access_complete;
  logic               invalid_address;
  logic [NR*DW-1:0]   hw_next;
  logic [NR-1:0]      hw_wen;
  logic [NR-1:0]      hw_inc;
  logic [NR*DW-1:0]   reg_q;

  param_rf #(
    .NUM_REGS  (NR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .SW_WR_MASK(4'b0111),
    .CNT_MASK  (4'b1000)
  ) dut (
    .clk            (clk),
    .res            (res),
    .address        (address),
    .read_en        (read_en),
    .write_en       (write_en),
    .write_data     (write_data),
    .read_data      (read_data),
    .access_complete(access_complete),
    .invalid_address(invalid_address),
    .hw_next        (hw_next),
    .hw_wen         (hw_wen),
    .hw_inc         (hw_inc),
    .reg_q          (reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_rd;
  logic          m_ac;
  logic          m_inv;
  logic [3:0]    wr_mask  = 4'b0111;
  logic [3:0]    cnt_mask = 4'b1000;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  // Apply the current inputs for one edge, advance the model, compare.
  task automatic tick();
    logic [DW-1:0] nxt [NR];
    logic          acc;
    logic          inv;
    if (res) begin
      for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
      m_rd = '0; m_ac = 1'b0; m_inv = 1'b0;
    end else begin
      acc = read_en || write_en;
      inv = acc && (int'(address) >= int'(NR));
      m_ac  = acc;
      m_inv = inv;
      if (read_en && !write_en) m_rd = inv ? '0 : m_regs[address[1:0]];
      for (int i = 0; i < int'(NR); i++) begin
        if (hw_wen[i])
          nxt[i] = hw_next[i*DW +: DW];
        else if (write_en && !inv && int'(address) == i && wr_mask[i])
          nxt[i] = write_data;
        else if (cnt_mask[i] && hw_inc[i])
          nxt[i] = m_regs[i] + 64'd1;
        else
          nxt[i] = m_regs[i];
      end
      for (int i = 0; i < int'(NR); i++) m_regs[i] = nxt[i];
    end
    @(posedge clk);
    #1;
    check("reg_q", reg_q, model_flat());
    check("read_data", {192'd0, read_data}, {192'd0, m_rd});
    check("access_complete", {255'd0, access_complete}, {255'd0, m_ac});
    check("invalid_address", {255'd0, invalid_address}, {255'd0, m_inv});
  endtask

  task automatic idle();
    res = 1'b0; read_en = 1'b0; write_en = 1'b0;
    hw_wen = '0; hw_inc = '0;
  endtask

  initial begin
    res = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0;
    write_data = '0; hw_next = '0; hw_wen = '0; hw_inc = '0;
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_rd = '0; m_ac = 1'b0; m_inv = 1'b0;

    // Reset for four cycles
    for (int k = 0; k < 4; k++) tick();
    check("reset_regq", reg_q, '0);
    check("reset_ac", {255'd0, access_complete}, 256'd0);

    // Write then read register 0
    idle(); write_en = 1'b1; address = 3'd0; write_data = 64'h555AAA555AAA555A; tick();
    check("wr0_ac", {255'd0, access_complete}, 256'd1);
    check("wr0_val", {192'd0, reg_q[63:0]}, {192'd0, 64'h555AAA555AAA555A});
    idle(); read_en = 1'b1; address = 3'd0; tick();
    check("rd0_data", {192'd0, read_data}, {192'd0, 64'h555AAA555AAA555A});

    // Hardware load wins over software write to register 1
    idle(); write_en = 1'b1; address = 3'd1; write_data = 64'h1;
    hw_wen = 4'b0010; hw_next = '0; hw_next[127:64] = 64'hDEAD; tick();
    check("hw_over_sw", {192'd0, reg_q[127:64]}, {192'd0, 64'hDEAD});
    check("hw_over_sw_ac", {255'd0, access_complete}, 256'd1);

    // Read-only counter ignores software write, then counts
    idle(); write_en = 1'b1; address = 3'd3; write_data = 64'hFFFF; tick();
    check("ro_write", {192'd0, reg_q[255:192]}, 256'd0);
    for (int k = 0; k < 3; k++) begin idle(); hw_inc = 4'b1000; tick(); end
    idle(); read_en = 1'b1; address = 3'd3; tick();
    check("cnt_read", {192'd0, read_data}, 256'd3);
    idle(); hw_wen = 4'b1000; hw_next[255:192] = 64'hFFFFFFFFFFFFFFFF; tick();
    idle(); hw_inc = 4'b1000; tick();
    check("cnt_wrap", {192'd0, reg_q[255:192]}, 256'd0);

    // Out-of-range read
    idle(); read_en = 1'b1; address = 3'd4; tick();
    check("inv_flag", {255'd0, invalid_address}, 256'd1);
    check("inv_data", {192'd0, read_data}, 256'd0);

    // Simultaneous read and write, then reset
    idle(); read_en = 1'b1; address = 3'd0; tick();
    idle(); read_en = 1'b1; write_en = 1'b1; address = 3'd2; write_data = 64'h77; tick();
    check("rw_reg2", {192'd0, reg_q[191:128]}, {192'd0, 64'h77});
    check("rw_hold", {192'd0, read_data}, {192'd0, 64'h555AAA555AAA555A});
    idle(); res = 1'b1; write_en = 1'b1; address = 3'd1; write_data = 64'h9; tick();
    check("res_ac", {255'd0, access_complete}, 256'd0);
    check("res_regq", reg_q, '0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      res        = ($urandom_range(0, 59) == 0);
      address    = AW'($urandom_range(0, 7));
      read_en    = ($urandom_range(0, 2) == 0);
      write_en   = ($urandom_range(0, 2) == 0);
      write_data = {$urandom, $urandom};
      for (int i = 0; i < int'(NR); i++) begin
        hw_wen[i] = ($urandom_range(0, 7) == 0);
        hw_next[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFFFFFFFFFE : {$urandom, $urandom};
      end
      hw_inc = NR'($urandom);
      tick();
    end

    idle(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
